// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier slice.
// Provides the controller state type, datapath widths, step encodings and
// the carry-save helpers used by the 8x8 Dadda cores.
package mul_seq_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_seq_state_t;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned HALF_W = 8;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned CORE_W = 2 * HALF_W;

  // Byte-pair selected on each step: bit 0 picks a's high byte, bit 1 b's.
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_HL = 2'd1;
  localparam logic [1:0] STEP_LH = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  typedef struct packed {
    logic [CORE_W-1:0] s;
    logic [CORE_W-1:0] c;
  } csa_t;

  // 3:2 carry-save row; carry is pre-shifted into its column weight.
  function automatic csa_t csa3(input logic [CORE_W-1:0] x,
                                input logic [CORE_W-1:0] y,
                                input logic [CORE_W-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

  // 4:2 compressor built from two chained 3:2 rows.
  function automatic csa_t csa42(input logic [CORE_W-1:0] w,
                                 input logic [CORE_W-1:0] x,
                                 input logic [CORE_W-1:0] y,
                                 input logic [CORE_W-1:0] z);
    csa_t t;
    t = csa3(w, x, y);
    return csa3(t.s, t.c, z);
  endfunction

endpackage

// File: rtl/dadda_mul16_seq_core.sv
// 8x8 unsigned combinational multiplier cores.
//   x, y : 8-bit operands
//   p    : 16-bit product
// dadda_8x8_compressed reduces the eight partial-product rows along the
// Dadda height sequence 8-6-4-3-2 with 3:2 rows; dadda_8x8_compressed_ld
// uses a shallower 4:2 compressor tree. Both end in one carry-propagate add.
// Rows are truncated to 16 bits: the true product fits, so dropped carries
// out of bit 15 cancel in modular arithmetic.
module dadda_8x8_compressed
  import mul_seq_pkg::*;
(
  input  logic [HALF_W-1:0] x,
  input  logic [HALF_W-1:0] y,
  output logic [CORE_W-1:0] p
);

  logic [CORE_W-1:0] pp [HALF_W];
  csa_t l1a, l1b, l2a, l2b, l3, l4;

  for (genvar i = 0; i < HALF_W; i++) begin : g_pp
    assign pp[i] = y[i] ? (CORE_W'(x) << i) : '0;
  end

  assign l1a = csa3(pp[0], pp[1], pp[2]);
  assign l1b = csa3(pp[3], pp[4], pp[5]);
  assign l2a = csa3(l1a.s, l1a.c, l1b.s);
  assign l2b = csa3(l1b.c, pp[6], pp[7]);
  assign l3  = csa3(l2a.s, l2a.c, l2b.s);
  assign l4  = csa3(l3.s, l3.c, l2b.c);
  assign p   = l4.s + l4.c;

endmodule

module dadda_8x8_compressed_ld
  import mul_seq_pkg::*;
(
  input  logic [HALF_W-1:0] x,
  input  logic [HALF_W-1:0] y,
  output logic [CORE_W-1:0] p
);

  logic [CORE_W-1:0] pp [HALF_W];
  csa_t l1a, l1b, l2;

  for (genvar i = 0; i < HALF_W; i++) begin : g_pp
    assign pp[i] = y[i] ? (CORE_W'(x) << i) : '0;
  end

  assign l1a = csa42(pp[0], pp[1], pp[2], pp[3]);
  assign l1b = csa42(pp[4], pp[5], pp[6], pp[7]);
  assign l2  = csa42(l1a.s, l1a.c, l1b.s, l1b.c);
  assign p   = l2.s + l2.c;

endmodule

// File: rtl/dadda_mul16_seq.sv
// Sequential 16x16 unsigned multiplier around one shared 8x8 Dadda core.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake (a, b captured on accept)
//   out_valid/out_ready: product handshake
//   p                  : 32-bit product, held after the handshake
// Four byte-pair products are shift-accumulated on the cycles after accept.
module dadda_mul16_seq
  import mul_seq_pkg::*;
#(
  parameter bit USE_LD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p
);

  mul_seq_state_t    state;
  logic [1:0]        step;
  logic [OP_W-1:0]   a_r, b_r;
  logic [PROD_W-1:0] acc, p_r;
  logic [HALF_W-1:0] core_x, core_y;
  logic [CORE_W-1:0] core_p;
  logic [PROD_W-1:0] addend, acc_sum;

  if (USE_LD) begin : g_core_ld
    dadda_8x8_compressed_ld u_core (.x(core_x), .y(core_y), .p(core_p));
  end else begin : g_core
    dadda_8x8_compressed u_core (.x(core_x), .y(core_y), .p(core_p));
  end

  always_comb begin
    core_x = step[0] ? a_r[OP_W-1:HALF_W] : a_r[HALF_W-1:0];
    core_y = step[1] ? b_r[OP_W-1:HALF_W] : b_r[HALF_W-1:0];
    case (step)
      STEP_LL: addend = {16'b0, core_p};
      STEP_HL,
      STEP_LH: addend = {8'b0, core_p, 8'b0};
      default: addend = {core_p, 16'b0};
    endcase
    acc_sum = (step == STEP_LL) ? addend : acc + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= STEP_LL;
      acc   <= '0;
      p_r   <= '0;
      a_r   <= '0;
      b_r   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          acc   <= '0;
          step  <= STEP_LL;
          state <= MUL;
        end
        MUL: begin
          acc  <= acc_sum;
          step <= step + 2'd1;
          // p is a separate register so it keeps its value while the next
          // operation clears and rebuilds acc.
          if (step == STEP_HH) begin
            p_r   <= acc_sum;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign p         = p_r;

endmodule

// File: tb/tb_dadda_mul16_seq.sv
// Self-checking bench for dadda_mul16_seq; both core variants run in lockstep
// from the same stimulus and are checked against one scoreboard.
module tb_dadda_mul16_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] a, b;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] p0, p1;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  dadda_mul16_seq #(.USE_LD(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .p(p0));

  dadda_mul16_seq #(.USE_LD(1'b1)) dut_ld (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .p(p1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Product monitor: pops the scoreboard whenever a handshake is pending.
  always @(negedge clk) begin
    if (out_ready && (out_valid0 || out_valid1)) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [31:0] e;
        e = sb.pop_front();
        check("out_valid", 32'(out_valid0), 32'd1);
        check("out_valid_ld", 32'(out_valid1), 32'd1);
        check("p", p0, e);
        check("p_ld", p1, e);
      end
    end
  end

  task automatic expect_ctrl(input string tag, input logic ir, input logic ov);
    check({tag, "_in_ready"}, 32'(in_ready0), 32'(ir));
    check({tag, "_in_ready_ld"}, 32'(in_ready1), 32'(ir));
    check({tag, "_out_valid"}, 32'(out_valid0), 32'(ov));
    check({tag, "_out_valid_ld"}, 32'(out_valid1), 32'(ov));
  endtask

  // Waits (bounded) for in_ready, presents a/b, returns #1 after accept edge E0.
  task automatic start(input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready0 && in_ready1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(in_ready0 && in_ready1), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input int stall, input bit noise);
    logic [31:0] e;
    e = {16'b0, x} * {16'b0, y};
    out_ready = (stall == 0);
    start(x, y);
    sb.push_back(e);
    if (noise) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
    end
    repeat (4) begin
      @(negedge clk);
      expect_ctrl("mul", 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    expect_ctrl("done", 1'b0, 1'b1);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        expect_ctrl("stall", 1'b0, 1'b1);
        check("stall_p", p0, e);
        check("stall_p_ld", p1, e);
        if (s != stall - 1) @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    expect_ctrl("after_hs", 1'b1, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    expect_ctrl("reset", 1'b0, 1'b0);
    check("reset_p", p0, 32'h0);
    check("reset_p_ld", p1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_ctrl("post_reset", 1'b1, 1'b0);

    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(16'h1234, 16'h5678, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 0, 1'b0);
    run_op(16'h00FF, 16'h0100, 0, 1'b0);
    run_op(16'hABCD, 16'h0000, 3, 1'b0);
    run_op(16'h0F0F, 16'h00F1, 0, 1'b1);
    run_op(16'h0002, 16'h0003, 0, 1'b0);

    // Reset mid-flight (step 2): the operation must vanish.
    out_ready = 1'b1;
    start(16'hFFFF, 16'h0002);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready0), 32'd0);
    check("rst_in_ready_ld", 32'(in_ready1), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      expect_ctrl("aborted", 1'b1, 1'b0);
      check("aborted_p", p0, 32'h0);
      check("aborted_p_ld", p1, 32'h0);
    end
    run_op(16'h0003, 16'h0005, 0, 1'b0);

    for (int i = 0; i < 8; i++)
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(2, 0)), 1'($urandom));

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
